// File: rtl/spi_master_ctrl_if.sv
// Purpose: bundles the host handshake and SPI pins of spi_master_ctrl.
// Latency: n/a (wires only).
// Backpressure: start is honoured only while busy is low; there is no queueing.
// Ports: start/cpol/cpha/in_data (host -> ctrl), busy/done/read_data (ctrl -> host),
//        sclk/cs_n/mosi (ctrl -> slave), miso (slave -> ctrl).
interface spi_master_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              start;
  logic              cpol;
  logic              cpha;
  logic [DATA_W-1:0] in_data;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] read_data;
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;

  // The SPI master controller side.
  modport master (
    input  start, cpol, cpha, in_data, miso,
    output busy, done, read_data, sclk, cs_n, mosi
  );

  // The host / bench side driving the controller.
  modport slave (
    output start, cpol, cpha, in_data, miso,
    input  busy, done, read_data, sclk, cs_n, mosi
  );
endinterface

// File: rtl/spi_master_ctrl.sv
// Purpose: SPI master, all four CPOL/CPHA modes, LSB-first, full-duplex DATA_W-bit transfers.
// Latency: done = start cycle + 1 + (2*DATA_W+1)*CLK_DIV; all outputs registered.
// Backpressure: start ignored while busy (busy also covers the done cycle); no queueing.
// Ports: clk, reset (sync, active-high), bus (spi_master_ctrl_if.master).
module spi_master_ctrl #(
  parameter int DATA_W  = 8,
  parameter int CLK_DIV = 2
) (
  input  logic                clk,
  input  logic                reset,
  spi_master_ctrl_if.master   bus
);

  localparam int EDGES = 2 * DATA_W;
  localparam int EW    = $clog2(EDGES + 1);
  localparam int DW_C  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  state_t            state, state_nxt;
  logic              accept;
  logic [DW_C-1:0]   div_cnt;
  logic              tick;
  logic [EW-1:0]     edge_cnt;     // number of SCLK edges already produced (k-1 for the next edge)
  logic              cpha_l;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic              leading;
  logic              last_edge;
  logic              do_drive;
  logic              do_sample;

  logic              sclk_q;
  logic              cs_n_q;
  logic              mosi_q;
  logic              busy_q;
  logic              done_q;
  logic [DATA_W-1:0] rd_q;

  // Divider restarts when a transfer is accepted, so tick n lands CLK_DIV*n cycles after cs_n falls.
  assign tick      = (div_cnt == DW_C'(CLK_DIV - 1));
  // Next edge is odd-numbered (leading) when an even number of edges has been produced.
  assign leading   = ~edge_cnt[0];
  assign last_edge = (edge_cnt == EW'(EDGES - 1));
  // cpha=0: drive on trailing edges except the final one; cpha=1: drive on leading edges.
  assign do_drive  = (leading == cpha_l) && !last_edge;
  assign do_sample = leading ^ cpha_l;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !busy_q) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end
      end
      SETUP:   if (tick) state_nxt = SHIFT;
      SHIFT:   if (tick && last_edge) state_nxt = HOLD;
      HOLD:    if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      cpha_l   <= 1'b0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      sclk_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      mosi_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rd_q     <= '0;
    end else begin
      done_q <= 1'b0;

      if (accept || tick) div_cnt <= '0;
      else                div_cnt <= div_cnt + DW_C'(1);

      case (state)
        IDLE: begin
          // Idle level follows cpol; the value present at accept becomes the transfer's polarity.
          sclk_q <= bus.cpol;
          // busy stays high through the done cycle and clears one cycle later.
          busy_q <= 1'b0;
          if (accept) begin
            cpha_l   <= bus.cpha;
            cs_n_q   <= 1'b0;
            busy_q   <= 1'b1;
            edge_cnt <= '0;
            rx_sr    <= '0;
            if (bus.cpha) begin
              tx_sr  <= bus.in_data;
              mosi_q <= 1'b0;
            end else begin
              tx_sr  <= bus.in_data >> 1;
              mosi_q <= bus.in_data[0];
            end
          end
        end
        SETUP, SHIFT: begin
          if (tick) begin
            sclk_q   <= ~sclk_q;
            edge_cnt <= edge_cnt + EW'(1);
            if (do_drive) begin
              mosi_q <= tx_sr[0];
              tx_sr  <= tx_sr >> 1;
            end
            // Shift in at the MSB: after DATA_W samples the first one sits at bit 0.
            if (do_sample) rx_sr <= {bus.miso, rx_sr[DATA_W-1:1]};
          end
        end
        HOLD: begin
          if (tick) begin
            cs_n_q <= 1'b1;
            done_q <= 1'b1;
            rd_q   <= rx_sr;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sclk      = sclk_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.mosi      = mosi_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.read_data = rd_q;

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Purpose: self-checking bench for spi_master_ctrl (8-bit/CLK_DIV=2 and 16-bit/CLK_DIV=1 instances).
// Latency: n/a.
// Backpressure: n/a.
module tb_spi_master_ctrl;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  spi_master_ctrl_if #(.DATA_W(8))  if0 ();
  spi_master_ctrl_if #(.DATA_W(16)) if1 ();

  spi_master_ctrl #(.DATA_W(8), .CLK_DIV(2)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if0.master)
  );

  spi_master_ctrl #(.DATA_W(16), .CLK_DIV(1)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (if1.master)
  );

  int tests = 0;
  int fails = 0;

  // Loopback select and an LSB-first SPI slave model for dut0.
  logic       lb;
  logic [7:0] s_data;
  logic [7:0] s_tx;
  logic [7:0] s_rx;
  logic       s_miso;
  logic       cs_prev;
  logic       sclk_prev;

  assign if0.miso = lb ? if0.mosi : s_miso;
  assign if1.miso = if1.mosi;

  initial begin
    s_miso    = 1'b0;
    s_tx      = '0;
    s_rx      = '0;
    cs_prev   = 1'b1;
    sclk_prev = 1'b0;
  end

  always @(if0.sclk or if0.cs_n) begin
    if (if0.cs_n === 1'b0 && cs_prev !== 1'b0) begin
      s_rx = '0;
      s_tx = s_data;
      if (if0.cpha) s_miso = 1'b0;
      else begin
        s_miso = s_tx[0];
        s_tx   = s_tx >> 1;
      end
    end else if (if0.cs_n === 1'b0 && if0.sclk !== sclk_prev) begin
      if ((if0.sclk != if0.cpol) != if0.cpha) s_rx = {if0.mosi, s_rx[7:1]};
      else begin
        s_miso = s_tx[0];
        s_tx   = s_tx >> 1;
      end
    end
    cs_prev   = if0.cs_n;
    sclk_prev = if0.sclk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called in the first cycle after the start cycle; returns the cycle offset of done.
  task automatic wait_done(output int cyc, output int cs_low, output int edges);
    logic sp;
    cyc    = 1;
    cs_low = 0;
    edges  = 0;
    sp     = if0.sclk;
    while (if0.done !== 1'b1 && cyc < 100) begin
      if (if0.cs_n === 1'b0) cs_low++;
      @(negedge clk);
      if (if0.sclk !== sp) edges++;
      sp = if0.sclk;
      cyc++;
    end
  endtask

  typedef struct {
    logic       cpol;
    logic       cpha;
    logic       lb;
    logic [7:0] tx;
    logic [7:0] sd;
    logic [7:0] exp_rd;
    logic [7:0] exp_srd;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int cyc, csl, edg, dones, done_at;

    vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h0F, 8'h00, 8'h0F, 8'h00};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h6E, 8'hD8, 8'hD8, 8'h6E};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h59, 8'h59, 8'h00};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 8'hFF, 8'h1B, 8'h1B, 8'hFF};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'h3C, 8'hA5, 8'hA5, 8'h3C};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 8'h96, 8'h00, 8'h96, 8'h00};

    reset       = 1'b1;
    lb          = 1'b1;
    s_data      = '0;
    if0.start   = 1'b0;
    if0.cpol    = 1'b1;
    if0.cpha    = 1'b0;
    if0.in_data = '0;
    if1.start   = 1'b0;
    if1.cpol    = 1'b0;
    if1.cpha    = 1'b0;
    if1.in_data = '0;

    repeat (3) @(negedge clk);
    chk("rst_sclk", 32'(if0.sclk), 32'd0);
    chk("rst_cs_n", 32'(if0.cs_n), 32'd1);
    chk("rst_mosi", 32'(if0.mosi), 32'd0);
    chk("rst_busy", 32'(if0.busy), 32'd0);
    chk("rst_done", 32'(if0.done), 32'd0);
    chk("rst_rd",   32'(if0.read_data), 32'd0);
    chk("rst_rd16", 32'(if1.read_data), 32'd0);
    reset = 1'b0;

    // Table-driven transfers over all four modes.
    for (int i = 0; i < 6; i++) begin
      if0.cpol    = vecs[i].cpol;
      if0.cpha    = vecs[i].cpha;
      lb          = vecs[i].lb;
      s_data      = vecs[i].sd;
      if0.in_data = vecs[i].tx;
      repeat (2) @(negedge clk);
      chk($sformatf("v%0d_idle_sclk", i), 32'(if0.sclk), 32'(vecs[i].cpol));
      if0.start = 1'b1;
      @(negedge clk);
      if0.start = 1'b0;
      chk($sformatf("v%0d_busy", i), 32'(if0.busy), 32'd1);
      wait_done(cyc, csl, edg);
      chk($sformatf("v%0d_latency", i), 32'(cyc), 32'd35);
      chk($sformatf("v%0d_cs_low", i), 32'(csl), 32'd34);
      chk($sformatf("v%0d_edges", i), 32'(edg), 32'd16);
      chk($sformatf("v%0d_read_data", i), 32'(if0.read_data), 32'(vecs[i].exp_rd));
      chk($sformatf("v%0d_cs_n_done", i), 32'(if0.cs_n), 32'd1);
      chk($sformatf("v%0d_sclk_done", i), 32'(if0.sclk), 32'(vecs[i].cpol));
      if (!vecs[i].lb) chk($sformatf("v%0d_slave_rd", i), 32'(s_rx), 32'(vecs[i].exp_srd));
      @(negedge clk);
      chk($sformatf("v%0d_done_clr", i), 32'(if0.done), 32'd0);
      chk($sformatf("v%0d_busy_clr", i), 32'(if0.busy), 32'd0);
    end

    // Starts at +5 and in the done cycle are ignored; start at done+1 is taken.
    if0.cpol    = 1'b0;
    if0.cpha    = 1'b0;
    lb          = 1'b1;
    if0.in_data = 8'hA5;
    repeat (2) @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    cyc       = 1;
    dones     = 0;
    done_at   = 0;
    while (dones == 0 && cyc < 60) begin
      if (cyc == 5) begin
        chk("ign_busy5", 32'(if0.busy), 32'd1);
        if0.start   = 1'b1;
        if0.in_data = 8'h5A;
      end else if (cyc == 6) begin
        if0.start = 1'b0;
      end
      if (if0.done === 1'b1) begin
        dones++;
        done_at     = cyc;
        if0.start   = 1'b1;
        if0.in_data = 8'hC3;
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("ign_done_at", 32'(done_at), 32'd35);
    chk("ign_read_data", 32'(if0.read_data), 32'hA5);
    chk("ign_busy_done", 32'(if0.busy), 32'd1);
    @(negedge clk);
    chk("b2b_busy", 32'(if0.busy), 32'd0);
    chk("b2b_done", 32'(if0.done), 32'd0);
    @(negedge clk);
    if0.start = 1'b0;
    wait_done(cyc, csl, edg);
    chk("b2b_latency", 32'(cyc), 32'd35);
    chk("b2b_read_data", 32'(if0.read_data), 32'hC3);

    // Reset in the middle of a transfer aborts it with no done.
    @(negedge clk);
    if0.cpol    = 1'b1;
    if0.in_data = 8'h3C;
    repeat (2) @(negedge clk);
    if0.start = 1'b1;
    @(negedge clk);
    if0.start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_cs_n", 32'(if0.cs_n), 32'd1);
    chk("abort_sclk", 32'(if0.sclk), 32'd0);
    chk("abort_busy", 32'(if0.busy), 32'd0);
    chk("abort_rd",   32'(if0.read_data), 32'd0);
    chk("abort_done", 32'(if0.done), 32'd0);
    reset = 1'b0;
    dones = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (if0.done === 1'b1) dones++;
    end
    chk("abort_no_done", 32'(dones), 32'd0);

    // 16-bit, CLK_DIV=1 loopback.
    if1.in_data = 16'hA5C3;
    repeat (2) @(negedge clk);
    if1.start = 1'b1;
    @(negedge clk);
    if1.start = 1'b0;
    cyc = 1;
    csl = 0;
    while (if1.done !== 1'b1 && cyc < 100) begin
      if (if1.cs_n === 1'b0) csl++;
      @(negedge clk);
      cyc++;
    end
    chk("w16_latency", 32'(cyc), 32'd34);
    chk("w16_cs_low", 32'(csl), 32'd33);
    chk("w16_read_data", 32'(if1.read_data), 32'hA5C3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
